// File: rtl/msb_pkg.sv
// Shared defaults and helpers for the MSB normalizer.
package msb_pkg;

    // Default operand / mantissa width.
    localparam int unsigned DEFAULT_N  = 64;
    // Default position / exponent field width (2^PW > N).
    localparam int unsigned DEFAULT_PW = 8;
    // Position code meaning "operand is zero".
    localparam logic [DEFAULT_PW-1:0] ZERO_POS = '1;

    // Left-shift amount that moves bit 'pos' up to bit n-1.
    function automatic int unsigned calc_shamt(input int unsigned n, input int unsigned pos);
        return n - 1 - pos;
    endfunction

endpackage

// File: rtl/msb_normalize_if.sv
// Valid/ready operand and result bus for msb_normalize.
interface msb_normalize_if
    import msb_pkg::*;
#(
    parameter int unsigned N  = DEFAULT_N,
    parameter int unsigned PW = DEFAULT_PW
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_num;
    logic [PW-1:0] in_pos;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_mant;
    logic [PW-1:0] out_exp;
    logic          out_zero;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, in_num, in_pos, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero
    );

    // The normalizer itself.
    modport slave (
        input  in_valid, in_num, in_pos, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero
    );
endinterface

// File: rtl/msb_norm_shifter.sv
// Combinational logarithmic barrel left-shifter; shifts of N or more yield zero.
module msb_norm_shifter #(
    parameter int unsigned N  = 64,
    parameter int unsigned PW = 8
) (
    input  logic [N-1:0]  din,
    input  logic [PW-1:0] shamt,
    output logic [N-1:0]  dout
);
    localparam int unsigned LogN = $clog2(N);

    logic [N-1:0] stage [LogN+1];

    assign stage[0] = din;

    for (genvar g = 0; g < LogN; g++) begin : g_stage
        assign stage[g+1] = shamt[g] ? (stage[g] << (1 << g)) : stage[g];
    end

    // Any set bit above the log2(N) field means the whole operand shifts out.
    assign dout = (|shamt[PW-1:LogN]) ? '0 : stage[LogN];

endmodule

// File: rtl/msb_normalize.sv
// Two-stage valid/ready normalizer: shifts the operand so its leading one sits at bit N-1.
// Optional MSB_NORMALIZE_CHECK_EN adds a sticky chk_err flag that cross-checks in_pos.
module msb_normalize
    import msb_pkg::*;
#(
    parameter int unsigned N  = DEFAULT_N,
    parameter int unsigned PW = DEFAULT_PW
) (
    input  logic           clk,
    input  logic           rst,
    msb_normalize_if.slave bus
`ifdef MSB_NORMALIZE_CHECK_EN
    ,
    output logic           chk_err
`endif
);
    // Stage 1 state
    logic          s1_valid_q;
    logic [N-1:0]  num1_q;
    logic [PW-1:0] pos1_q;
    logic [PW-1:0] shamt1_q;
    logic          z1_q;

    // Stage 2 (output) state
    logic          out_valid_q;
    logic [N-1:0]  out_mant_q;
    logic [PW-1:0] out_exp_q;
    logic          out_zero_q;

    logic          s2_adv;
    logic          in_ready;
    logic          in_fire;
    logic [PW-1:0] shamt_in;
    logic          z_in;
    logic [N-1:0]  shifted;

    // Pipeline control: stage 2 drains when empty or consumed; reset blocks acceptance.
    always_comb begin
        s2_adv   = !out_valid_q || bus.out_ready;
        in_ready = !rst && (!s1_valid_q || s2_adv);
        in_fire  = bus.in_valid && in_ready;
        shamt_in = PW'(calc_shamt(N, 32'(bus.in_pos)));
        z_in     = (32'(bus.in_pos) > (N - 1));
    end

    // Stage 1 occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 1 payload capture; only meaningful while s1_valid_q is set.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            num1_q   <= bus.in_num;
            pos1_q   <= bus.in_pos;
            shamt1_q <= shamt_in;
            z1_q     <= z_in;
        end
    end

    msb_norm_shifter #(
        .N  (N),
        .PW (PW)
    ) u_shifter (
        .din   (num1_q),
        .shamt (shamt1_q),
        .dout  (shifted)
    );

    // Stage 2: register the normalized result; hold it while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_zero_q  <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_mant_q <= z1_q ? '0 : shifted;
                out_exp_q  <= z1_q ? '0 : pos1_q;
                out_zero_q <= z1_q;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_mant  = out_mant_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_zero  = out_zero_q;

`ifdef MSB_NORMALIZE_CHECK_EN
    logic [PW-1:0] msb_ref;
    logic          chk_err_q;

    // Independent priority search for the leading one; all-ones when operand is zero.
    always_comb begin
        msb_ref = '1;
        for (int i = 0; i < N; i++) begin
            if (bus.in_num[i]) msb_ref = PW'(i);
        end
    end

    // Sticky mismatch flag, evaluated on every accepted operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else if (in_fire && (msb_ref != bus.in_pos)) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_msb_normalize.sv
// Self-checking bench for msb_normalize (N=64, PW=8) with a behavioural result model.
module tb_msb_normalize;
    import msb_pkg::*;

    localparam int unsigned N  = 64;
    localparam int unsigned PW = 8;

    typedef struct packed {
        logic [N-1:0]  m;
        logic [PW-1:0] e;
        logic          z;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    msb_normalize_if #(.N(N), .PW(PW)) bus ();

`ifdef MSB_NORMALIZE_CHECK_EN
    logic chk_err;
`endif

    msb_normalize #(.N(N), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MSB_NORMALIZE_CHECK_EN
        ,
        .chk_err (chk_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected result: position out of range means zero; otherwise multiply by 2^(N-1-pos).
    function automatic res_t model(input logic [N-1:0] num, input logic [PW-1:0] pos);
        res_t r;
        if (int'(pos) >= int'(N)) begin
            r.m = '0; r.e = '0; r.z = 1'b1;
        end else begin
            r.m = num * (64'd1 << (int'(N) - 1 - int'(pos)));
            r.e = pos;
            r.z = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] lead_one(input logic [N-1:0] num);
        logic [PW-1:0] p;
        p = ZERO_POS;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (num[i]) begin
                p = PW'(i);
                break;
            end
        end
        return p;
    endfunction

    // Mostly consistent positions, plus zeros, wrong in-range and out-of-range positions.
    task automatic pick(output logic [N-1:0] num, output logic [PW-1:0] pos);
        int r;
        r   = $urandom_range(0, 9);
        num = {$urandom, $urandom} >> $urandom_range(0, 63);
        if (r < 7) begin
            pos = lead_one(num);
        end else if (r == 7) begin
            num = '0;
            pos = ZERO_POS;
        end else if (r == 8) begin
            pos = PW'($urandom_range(0, 63));
        end else begin
            pos = PW'($urandom_range(64, 254));
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_num = '0; bus.in_pos = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if ({bus.out_mant, bus.out_exp, bus.out_zero} !== '0) begin errors++;
            $display("FAIL reset_outputs: got %h/%0d/%b want 0", bus.out_mant, bus.out_exp,
                     bus.out_zero); end
`ifdef MSB_NORMALIZE_CHECK_EN
        checks++; if (chk_err !== 1'b0) begin errors++;
            $display("FAIL reset_chk_err: got %b want 0", chk_err); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [N-1:0]  dn [4] = '{64'h0000000000003131, 64'h3100000000003131, 64'h1, 64'h0};
        logic [PW-1:0] dp [4] = '{8'd13, 8'd61, 8'd0, 8'hFF};
        logic [N-1:0]  em [4] = '{64'hC4C4000000000000, 64'hC40000000000C4C4,
                                  64'h8000000000000000, 64'h0};
        logic [PW-1:0] ee [4] = '{8'd13, 8'd61, 8'd0, 8'd0};
        logic          ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1; bus.in_num = dn[k]; bus.in_pos = dp[k];
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++;
                $display("FAIL directed_accept[%0d]: in_ready %b want 1", k, bus.in_ready); end
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++; if (bus.out_valid !== 1'b0) begin errors++;
                $display("FAIL directed_latency1[%0d]: out_valid %b want 0", k, bus.out_valid); end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_mant !== em[k] || bus.out_exp !== ee[k] ||
                bus.out_zero !== ez[k]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got v=%b %h/%0d/%b want v=1 %h/%0d/%b", k,
                         bus.out_valid, bus.out_mant, bus.out_exp, bus.out_zero, em[k], ee[k],
                         ez[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t exp_r;
        logic [N-1:0]  n;
        logic [PW-1:0] p;
        int got = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            bus.in_valid = (c < 10);
            pick(n, p);
            bus.in_num = n; bus.in_pos = p;
            #1;
            if (c < 10) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++;
                    $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, bus.in_ready); end
            end
            if (c >= 2 && c < 12) begin
                checks++;
                if (bus.out_valid !== 1'b1 || q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_out_valid[%0d]: got %b want 1", c, bus.out_valid);
                end else begin
                    exp_r = q.pop_front();
                    got++;
                    if ({bus.out_mant, bus.out_exp, bus.out_zero} !== exp_r) begin
                        errors++;
                        $display("FAIL b2b_data[%0d]: got %h/%0d/%b want %h/%0d/%b", c,
                                 bus.out_mant, bus.out_exp, bus.out_zero, exp_r.m, exp_r.e,
                                 exp_r.z);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(n, p));
        end
        bus.in_valid = 1'b0;
        checks++; if (got != 10) begin errors++;
            $display("FAIL b2b_count: got %0d want 10", got); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0]  ops [4];
        logic [PW-1:0] pps [4];
        res_t snap;
        res_t exp_r;
        int idx = 0;
        int got = 0;
        for (int k = 0; k < 4; k++) begin
            ops[k] = {$urandom, $urandom} | 64'h1;
            pps[k] = lead_one(ops[k]);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            bus.in_valid = (idx < 4);
            if (idx < 4) begin bus.in_num = ops[idx]; bus.in_pos = pps[idx]; end
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
        end
        @(negedge clk);
        #1;
        checks++; if (idx != 2) begin errors++;
            $display("FAIL bp_accepted: got %0d want 2", idx); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        snap = {bus.out_mant, bus.out_exp, bus.out_zero};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_mant, bus.out_exp, bus.out_zero} !== snap ||
                bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable[%0d]: v=%b rdy=%b mant=%h want v=1 rdy=0 mant=%h", c,
                         bus.out_valid, bus.in_ready, bus.out_mant, snap.m);
            end
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (c > 0) @(negedge clk);
            bus.in_valid = (idx < 4);
            if (idx < 4) begin bus.in_num = ops[idx]; bus.in_pos = pps[idx]; end
            #1;
            if (bus.out_valid) begin
                exp_r = model(ops[got], pps[got]);
                checks++;
                if ({bus.out_mant, bus.out_exp, bus.out_zero} !== exp_r) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h/%0d want %h/%0d", got, bus.out_mant,
                             bus.out_exp, exp_r.m, exp_r.e);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
        end
        bus.in_valid = 1'b0;
        checks++; if (got != 4 || idx != 4) begin errors++;
            $display("FAIL bp_drain: got %0d results %0d accepted want 4/4", got, idx); end
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_no_dup: out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_in_flight();
        logic [N-1:0]  n;
        logic [PW-1:0] p;
        res_t exp_r;
        int acc = 0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6 && acc < 2; c++) begin
            if (c > 0) @(negedge clk);
            bus.in_valid = 1'b1; bus.in_num = 64'hFFFF_0000_1234_5678; bus.in_pos = 8'd63;
            #1;
            if (bus.in_ready) acc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL rif_full: v=%b rdy=%b want 1/0", bus.out_valid, bus.in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL rif_ready_in_rst: got %b want 0", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || {bus.out_mant, bus.out_exp, bus.out_zero} !== '0) begin
            errors++;
            $display("FAIL rif_cleared: v=%b %h/%0d/%b want 0", bus.out_valid, bus.out_mant,
                     bus.out_exp, bus.out_zero);
        end
        n = 64'h0000_0000_00F0_0000; p = lead_one(n);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_num = n; bus.in_pos = p;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL rif_stale: out_valid %b want 0", bus.out_valid); end
        @(negedge clk);
        exp_r = model(n, p);
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_mant, bus.out_exp, bus.out_zero} !== exp_r) begin
            errors++;
            $display("FAIL rif_new: v=%b %h/%0d want 1 %h/%0d", bus.out_valid, bus.out_mant,
                     bus.out_exp, exp_r.m, exp_r.e);
        end
    endtask

    task automatic test_random();
        res_t q[$];
        res_t snap;
        res_t exp_r;
        logic stall = 1'b0;
        logic hold  = 1'b0;
        logic [N-1:0]  n = '0;
        logic [PW-1:0] p = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (stall) begin
                checks++;
                if ({bus.out_mant, bus.out_exp, bus.out_zero} !== snap || bus.out_valid !== 1'b1)
                begin
                    errors++;
                    $display("FAIL rand_stall[%0d]: got %h/%0d want %h/%0d", c, bus.out_mant,
                             bus.out_exp, snap.m, snap.e);
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                bus.in_valid = (c < 360) && ($urandom_range(0, 2) != 0);
                pick(n, p);
                bus.in_num = n; bus.in_pos = p;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra[%0d]: unexpected result %h", c, bus.out_mant);
                end else begin
                    exp_r = q.pop_front();
                    if ({bus.out_mant, bus.out_exp, bus.out_zero} !== exp_r) begin
                        errors++;
                        $display("FAIL rand_data[%0d]: got %h/%0d/%b want %h/%0d/%b", c,
                                 bus.out_mant, bus.out_exp, bus.out_zero, exp_r.m, exp_r.e,
                                 exp_r.z);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(n, p));
            hold  = bus.in_valid && !bus.in_ready;
            stall = bus.out_valid && !bus.out_ready;
            snap  = {bus.out_mant, bus.out_exp, bus.out_zero};
        end
        bus.in_valid = 1'b0;
        checks++; if (q.size() != 0) begin errors++;
            $display("FAIL rand_leftover: %0d results missing want 0", q.size()); end
    endtask

`ifdef MSB_NORMALIZE_CHECK_EN
    task automatic test_checker();
        logic [N-1:0] n;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (chk_err !== 1'b0) begin errors++;
            $display("FAIL chk_clear: got %b want 0", chk_err); end
        bus.in_valid = 1'b1; bus.in_num = 64'h3131; bus.in_pos = 8'd12;
        @(negedge clk);
        checks++; if (chk_err !== 1'b1) begin errors++;
            $display("FAIL chk_set: got %b want 1", chk_err); end
        for (int k = 0; k < 3; k++) begin
            n = {$urandom, $urandom} | 64'h1;
            bus.in_num = n; bus.in_pos = lead_one(n);
            @(negedge clk);
            checks++; if (chk_err !== 1'b1) begin errors++;
                $display("FAIL chk_sticky[%0d]: got %b want 1", k, chk_err); end
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (chk_err !== 1'b0) begin errors++;
            $display("FAIL chk_reset: got %b want 0", chk_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_in_flight();
        test_random();
`ifdef MSB_NORMALIZE_CHECK_EN
        test_checker();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
